// File: rtl/bus_dec_pkg.sv
// Shared types and helpers for the bus address decoder.
// Contents:
//   dec_state_e  - decoder state encoding (IDLE, REQ, RESP, ERR)
//   region_idx() - extracts the region index (top region_w bits) from an address.
//                  The arbiter and scoreboards also use it, so it takes the
//                  widths as arguments rather than baking in one configuration.
package bus_dec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } dec_state_e;

  localparam int unsigned MAX_ADDR_W   = 32;
  localparam int unsigned MAX_REGION_W = 8;

  function automatic logic [MAX_REGION_W-1:0] region_idx(
    input logic [MAX_ADDR_W-1:0] addr,
    input int unsigned           addr_w,
    input int unsigned           region_w
  );
    logic [MAX_ADDR_W-1:0] shifted;
    logic [MAX_ADDR_W-1:0] mask;
    shifted = addr >> (addr_w - region_w);
    mask    = (MAX_ADDR_W'(1) << region_w) - MAX_ADDR_W'(1);
    return MAX_REGION_W'(shifted & mask);
  endfunction

endpackage

// File: rtl/dec_watchdog.sv
// Watchdog for the bus address decoder (built only with DEC_TIMEOUT_EN).
// Down-counter loaded with TIMEOUT_CYC-1; expiry is the terminal count (zero)
// seen while running, i.e. on the TIMEOUT_CYC-th running cycle after a clear.
// Ports:
//   i_clk     - bus clock, rising edge
//   i_rst     - synchronous reset, active-high
//   i_clr     - reload the counter (state change or not running)
//   i_run     - decoder is waiting on a slave (REQ or RESP)
//   o_expired - terminal count reached while running
module dec_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_run,
  output logic o_expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= LOAD_VAL;
    end else if (i_run && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_expired = i_run && (r_cnt == '0);

endmodule

// File: rtl/bus_addr_decoder.sv
// Bus address decoder: turns the top REGION_W address bits into a registered
// one-hot slave select, holds it through the request phase, then holds a
// response-mux index until the response completes. Unmapped regions produce
// a one-cycle dec_err pulse.
// Optional feature: define DEC_TIMEOUT_EN to add a watchdog that aborts a
// transaction stuck in REQ/RESP for TIMEOUT_CYC cycles (timeout + dec_err).
// Ports:
//   i_clk, i_rst     - clock (rising edge), synchronous active-high reset
//   i_addr_valid     - new address presented (ignored while o_busy)
//   i_addr           - transaction address
//   i_txn_done       - selected slave finished its request phase
//   i_resp_done      - response delivered to the master
//   o_busy           - decoder not idle
//   o_slave_sel      - one-hot slave select during the request phase
//   o_resp_sel       - responding slave index for the response mux
//   o_resp_active    - o_resp_sel is valid
//   o_dec_err        - one-cycle pulse: unmapped address or timeout
//   o_timeout        - one-cycle pulse: watchdog expiry (0 without DEC_TIMEOUT_EN)
//
// state | meaning
// IDLE  | waiting for addr_valid
// REQ   | slave_sel driven, waiting for txn_done
// RESP  | resp_sel/resp_active driven, waiting for resp_done
// ERR   | single cycle, dec_err (and timeout on watchdog expiry) asserted
module bus_addr_decoder
  import bus_dec_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned NUM_SLAVES  = 3,
  parameter int unsigned REGION_W    = 4,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_addr_valid,
  input  logic [ADDR_W-1:0]                  i_addr,
  output logic                               o_busy,
  output logic [NUM_SLAVES-1:0]              o_slave_sel,
  input  logic                               i_txn_done,
  output logic [((NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1)-1:0] o_resp_sel,
  output logic                               o_resp_active,
  input  logic                               i_resp_done,
  output logic                               o_dec_err,
  output logic                               o_timeout
);

  localparam int unsigned SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  dec_state_e              r_state;
  logic                    r_busy;
  logic [NUM_SLAVES-1:0]   r_slave_sel;
  logic [SEL_W-1:0]        r_resp_sel;
  logic                    r_resp_active;
  logic                    r_dec_err;
  logic                    w_expired;
  logic [MAX_REGION_W-1:0] w_idx;
  logic                    w_mapped;
  logic [NUM_SLAVES-1:0]   w_onehot;

  assign w_idx    = region_idx(MAX_ADDR_W'(i_addr), ADDR_W, REGION_W);
  // One extra bit so NUM_SLAVES == 2**MAX_REGION_W still compares correctly.
  assign w_mapped = ({1'b0, w_idx} < (MAX_REGION_W + 1)'(NUM_SLAVES));
  assign w_onehot = NUM_SLAVES'(1) << w_idx;

`ifdef DEC_TIMEOUT_EN
  logic r_timeout;
  logic w_wd_run;
  logic w_wd_clr;

  assign w_wd_run = (r_state == REQ) || (r_state == RESP);
  // Reload whenever the FSM is about to leave REQ/RESP or is not waiting at all,
  // so the first cycle of every REQ/RESP stay starts from a full count.
  assign w_wd_clr = !w_wd_run
                 || ((r_state == REQ)  && i_txn_done)
                 || ((r_state == RESP) && i_resp_done);

  dec_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (w_wd_clr),
    .i_run     (w_wd_run),
    .o_expired (w_expired)
  );

  assign o_timeout = r_timeout;
`else
  // TIMEOUT_CYC is kept on the interface so both builds share one parameter list.
  localparam logic TMO_TIE = (TIMEOUT_CYC == 0) ? 1'b0 : 1'b0;

  assign w_expired = 1'b0;
  assign o_timeout = TMO_TIE;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_busy        <= 1'b0;
      r_slave_sel   <= '0;
      r_resp_sel    <= '0;
      r_resp_active <= 1'b0;
      r_dec_err     <= 1'b0;
`ifdef DEC_TIMEOUT_EN
      r_timeout     <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (i_addr_valid) begin
            r_busy <= 1'b1;
            if (w_mapped) begin
              r_state     <= REQ;
              r_slave_sel <= w_onehot;
              r_resp_sel  <= w_idx[SEL_W-1:0];
            end else begin
              r_state   <= ERR;
              r_dec_err <= 1'b1;
            end
          end
        end
        REQ: begin
          // Completions are checked before expiry so a late-but-valid finish wins.
          if (i_txn_done && i_resp_done) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_slave_sel <= '0;
            r_resp_sel  <= '0;
          end else if (i_txn_done) begin
            r_state       <= RESP;
            r_slave_sel   <= '0;
            r_resp_active <= 1'b1;
          end else if (w_expired) begin
            r_state     <= ERR;
            r_slave_sel <= '0;
            r_resp_sel  <= '0;
            r_dec_err   <= 1'b1;
`ifdef DEC_TIMEOUT_EN
            r_timeout   <= 1'b1;
`endif
          end
        end
        RESP: begin
          if (i_resp_done) begin
            r_state       <= IDLE;
            r_busy        <= 1'b0;
            r_resp_active <= 1'b0;
            r_resp_sel    <= '0;
          end else if (w_expired) begin
            r_state       <= ERR;
            r_resp_active <= 1'b0;
            r_resp_sel    <= '0;
            r_dec_err     <= 1'b1;
`ifdef DEC_TIMEOUT_EN
            r_timeout     <= 1'b1;
`endif
          end
        end
        ERR: begin
          r_state   <= IDLE;
          r_busy    <= 1'b0;
          r_dec_err <= 1'b0;
`ifdef DEC_TIMEOUT_EN
          r_timeout <= 1'b0;
`endif
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_slave_sel   = r_slave_sel;
  assign o_resp_sel    = r_resp_sel;
  assign o_resp_active = r_resp_active;
  assign o_dec_err     = r_dec_err;

endmodule

// File: tb/tb_bus_addr_decoder.sv
// Scoreboard bench for bus_addr_decoder (default parameters, TIMEOUT_CYC=8).
// Stimulus pushes every expected change of the output vector together with the
// cycle it must appear in; a negedge monitor pops one entry per observed change.
module tb_bus_addr_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        av;
  logic [15:0] addr;
  logic        td;
  logic        rd;
  logic        busy;
  logic [2:0]  sel;
  logic [1:0]  rsel;
  logic        ract;
  logic        err;
  logic        tmo;

  bus_addr_decoder #(
    .ADDR_W      (16),
    .NUM_SLAVES  (3),
    .REGION_W    (4),
    .TIMEOUT_CYC (8)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_addr_valid  (av),
    .i_addr        (addr),
    .o_busy        (busy),
    .o_slave_sel   (sel),
    .i_txn_done    (td),
    .o_resp_sel    (rsel),
    .o_resp_active (ract),
    .i_resp_done   (rd),
    .o_dec_err     (err),
    .o_timeout     (tmo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [8:0] vec;
    string      name;
  } exp_t;

  exp_t       q[$];
  exp_t       m_e;
  int         n_tests = 0;
  int         n_fail  = 0;
  bit         mon_en  = 1'b0;
  bit         first   = 1'b1;
  logic [8:0] last;
  logic [8:0] w_obs;

  assign w_obs = {busy, sel, rsel, ract, err, tmo};

  // vector layout: busy | slave_sel[2:0] | resp_sel[1:0] | resp_active | dec_err | timeout
  function automatic logic [8:0] ev(bit b, logic [2:0] s, logic [1:0] r, bit a, bit e, bit t);
    return {b, s, r, a, e, t};
  endfunction

  always @(negedge clk) begin
    if (mon_en && (first || (w_obs !== last))) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change cyc=%0d got=%b (no change expected)", cyc, w_obs);
      end else begin
        m_e = q.pop_front();
        if ((w_obs !== m_e.vec) || (cyc != m_e.cyc))
        begin
          n_fail++;
          $display("FAIL %s: got %b at cyc %0d, expected %b at cyc %0d",
                   m_e.name, w_obs, cyc, m_e.vec, m_e.cyc);
        end
      end
      last  = w_obs;
      first = 1'b0;
    end
  end

  // One cycle of stimulus; if chg, the outputs must change to exp at the next edge.
  task automatic drive(string nm, bit v, logic [15:0] a, bit t, bit r, bit rs,
                       bit chg, logic [8:0] exp);
    av = v; addr = a; td = t; rd = r; rst = rs;
    if (chg) q.push_back('{cyc: cyc + 1, vec: exp, name: nm});
    @(posedge clk);
    #1;
    av = 1'b0; addr = 16'h0; td = 1'b0; rd = 1'b0; rst = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int budget;
    rst = 1'b1; av = 1'b0; addr = 16'h0; td = 1'b0; rd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q.push_back('{cyc: cyc, vec: ev(0, 3'b000, 2'd0, 0, 0, 0), name: "reset"});
    mon_en = 1'b1;
    idle(2);

    // single transaction to slave 1
    drive("req_s1",            1, 16'h1002, 0, 0, 0, 1, ev(1, 3'b010, 2'd1, 0, 0, 0));
    idle(2);
    drive("rd_in_req_ignored", 0, 16'h0000, 0, 1, 0, 0, '0);
    drive("resp_s1",           0, 16'h0000, 1, 0, 0, 1, ev(1, 3'b000, 2'd1, 1, 0, 0));
    drive("td_in_resp_ignored",0, 16'h0000, 1, 0, 0, 0, '0);
    drive("idle_after_s1",     0, 16'h0000, 0, 1, 0, 1, ev(0, 3'b000, 2'd0, 0, 0, 0));
    drive("td_in_idle_ignored",0, 16'h0000, 1, 0, 0, 0, '0);

    // back-to-back: second address while busy is dropped
    drive("req_s0",            1, 16'h0001, 0, 0, 0, 1, ev(1, 3'b001, 2'd0, 0, 0, 0));
    drive("busy_addr_ignored", 1, 16'h2003, 0, 0, 0, 0, '0);
    drive("resp_s0",           0, 16'h0000, 1, 0, 0, 1, ev(1, 3'b000, 2'd0, 1, 0, 0));
    drive("idle_after_s0",     0, 16'h0000, 0, 1, 0, 1, ev(0, 3'b000, 2'd0, 0, 0, 0));
    drive("req_s2",            1, 16'h2003, 0, 0, 0, 1, ev(1, 3'b100, 2'd2, 0, 0, 0));
    drive("resp_s2",           0, 16'h0000, 1, 0, 0, 1, ev(1, 3'b000, 2'd2, 1, 0, 0));
    drive("idle_after_s2",     0, 16'h0000, 0, 1, 0, 1, ev(0, 3'b000, 2'd0, 0, 0, 0));

    // unmapped regions: one-cycle error, then idle
    drive("unmapped_err",      1, 16'h5000, 0, 0, 0, 1, ev(1, 3'b000, 2'd0, 0, 1, 0));
    drive("unmapped_clear",    0, 16'h0000, 0, 0, 0, 1, ev(0, 3'b000, 2'd0, 0, 0, 0));
    idle(1);
    drive("boundary_err",      1, 16'h3FFF, 0, 0, 0, 1, ev(1, 3'b000, 2'd0, 0, 1, 0));
    drive("boundary_clear",    0, 16'h0000, 0, 0, 0, 1, ev(0, 3'b000, 2'd0, 0, 0, 0));

    // txn_done and resp_done together in REQ: straight back to idle
    drive("req_s0_fast",       1, 16'h0000, 0, 0, 0, 1, ev(1, 3'b001, 2'd0, 0, 0, 0));
    drive("fast_done",         0, 16'h0000, 1, 1, 0, 1, ev(0, 3'b000, 2'd0, 0, 0, 0));
    idle(1);

    // reset in RESP aborts
    drive("req_s1_rst",        1, 16'h1FFF, 0, 0, 0, 1, ev(1, 3'b010, 2'd1, 0, 0, 0));
    drive("resp_s1_rst",       0, 16'h0000, 1, 0, 0, 1, ev(1, 3'b000, 2'd1, 1, 0, 0));
    drive("rst_in_resp",       0, 16'h0000, 0, 0, 1, 1, ev(0, 3'b000, 2'd0, 0, 0, 0));
    idle(1);

    // stuck request
    drive("req_stuck",         1, 16'h0000, 0, 0, 0, 1, ev(1, 3'b001, 2'd0, 0, 0, 0));
`ifdef DEC_TIMEOUT_EN
    q.push_back('{cyc: cyc + 8, vec: ev(1, 3'b000, 2'd0, 0, 1, 1), name: "timeout"});
    q.push_back('{cyc: cyc + 9, vec: ev(0, 3'b000, 2'd0, 0, 0, 0), name: "timeout_clear"});
    idle(12);
`else
    idle(20);
    drive("stuck_resp",        0, 16'h0000, 1, 0, 0, 1, ev(1, 3'b000, 2'd0, 1, 0, 0));
    drive("stuck_idle",        0, 16'h0000, 0, 1, 0, 1, ev(0, 3'b000, 2'd0, 0, 0, 0));
`endif

    budget = 0;
    while ((q.size() != 0) && (budget < 50)) begin
      @(posedge clk);
      budget++;
    end
    #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected changes never seen, required 0", q.size());
    end
    idle(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
